// File: rtl/matrix_pkg.sv
// Shared constants and state encoding for the matrix_loader block.
package matrix_pkg;

  localparam int unsigned DIM       = 6;
  localparam int unsigned WORD      = 32;
  localparam int unsigned NUM_WORDS = 2 * DIM * DIM;
  localparam int unsigned IDX_W     = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    FULL
  } state_e;

endpackage

// File: rtl/matrix_bank.sv
// DIM x DIM register file written one element at a time, read as a flat bus.
module matrix_bank #(
  parameter int unsigned DIM  = matrix_pkg::DIM,
  parameter int unsigned WORD = matrix_pkg::WORD,
  parameter int unsigned AW   = $clog2(DIM * DIM)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      we_i,
  input  logic [AW-1:0]             idx_i,
  input  logic [WORD-1:0]           wdata_i,
  output logic [DIM*DIM*WORD-1:0]   mat_o
);

  logic [DIM*DIM*WORD-1:0] mat_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mat_q <= '0;
    end else if (we_i) begin
      mat_q[idx_i*WORD +: WORD] <= wdata_i;
    end
  end

  assign mat_o = mat_q;

endmodule

// File: rtl/matrix_loader.sv
// Serial-to-parallel loader for two DIM x DIM operand matrices (A then B).
// Optional running checksum of accepted words: define MATRIX_LOADER_SUM_EN.
module matrix_loader #(
  parameter int unsigned DIM  = matrix_pkg::DIM,
  parameter int unsigned WORD = matrix_pkg::WORD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DIM*DIM*WORD-1:0] mat_a,
  output logic [DIM*DIM*WORD-1:0] mat_b,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MATRIX_LOADER_SUM_EN
  ,
  output logic [WORD-1:0]         checksum
`endif
);

  import matrix_pkg::*;

  localparam int unsigned CELLS = DIM * DIM;
  localparam int unsigned KW    = $clog2(2 * CELLS);
  localparam int unsigned AW    = $clog2(CELLS);

  state_e          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic            accept;
  logic            we_a, we_b;
  logic [AW-1:0]   a_idx, b_idx;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q == FULL);
  assign accept    = in_valid && in_ready;
  assign we_a      = accept && (state_q == LOAD_A);
  assign we_b      = accept && (state_q == LOAD_B);
  assign a_idx     = AW'(k_q);
  assign b_idx     = AW'(k_q - KW'(CELLS));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      LOAD_A: begin
        if (accept) begin
          k_d = k_q + 1'b1;
          if (k_q == KW'(CELLS - 1)) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        // The counter parks on the last index while full instead of overflowing.
        if (accept) begin
          if (k_q == KW'(2 * CELLS - 1)) begin
            state_d = FULL;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = LOAD_A;
          k_d     = '0;
        end
      end
      default: begin
        state_d = LOAD_A;
        k_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  matrix_bank #(
    .DIM  (DIM),
    .WORD (WORD),
    .AW   (AW)
  ) u_bank_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we_a),
    .idx_i   (a_idx),
    .wdata_i (in_data),
    .mat_o   (mat_a)
  );

  matrix_bank #(
    .DIM  (DIM),
    .WORD (WORD),
    .AW   (AW)
  ) u_bank_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we_b),
    .idx_i   (b_idx),
    .wdata_i (in_data),
    .mat_o   (mat_b)
  );

`ifdef MATRIX_LOADER_SUM_EN
  logic [WORD-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == FULL && out_ready) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

endmodule
